l1_bus_ctrl: RTL and testbench



---
 rtl/l1_ctrl_pkg.sv | 10 +
 rtl/l1_rr_arb.sv | 30 +++
 rtl/l1_bus_ctrl.sv | 157 +++++++++++++++
 tb/tb_l1_bus_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/l1_ctrl_pkg.sv
// Shared types and constants for the L1 bus sequencing controller.
//   state_e : controller FSM states
//   kind_e  : latched request kind (line fill, single read, write-through)
package l1_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LINE, SINGLE, DONE, ERR} state_e;
  typedef enum logic [1:0] {LINE_K, RD_K, WT_K} kind_e;

  localparam int         LINE_BEATS = 256;
  localparam logic [3:0] SIZE_DW    = 4'b1000;
endpackage

// File: rtl/l1_rr_arb.sv
// 2-way round-robin arbiter.
//   clk, rst : clock, async active-low reset
//   req      : per-port request levels
//   advance  : one-cycle pulse when the current grant completes; flips priority
//   gnt      : one-hot grant (combinational from req and the pointer)
module l1_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ptr_q <= 1'b0;
    else if (advance) ptr_q <= ~ptr_q;
  end

  always_comb begin
    gnt = 2'b00;
    if (!ptr_q) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end
endmodule

// File: rtl/l1_bus_ctrl.sv
// Sequencing controller behind the I/D L1 caches. Arbitrates two L1 ports
// onto a single-beat bus master and runs line fills, single reads and
// write-throughs.
//   req_line/req_rd/req_wt : per-port request levels (port0 = I, port1 = D)
//   req_size/req_pa/req_wdata : {p1,p0} packed request attributes
//   line_data, addr_count, line_write : fill data path into the L1 arrays
//   entry_write, trans_rdy, bus_error : per-port completion pulses
//   bus_* : single-beat bus master
module l1_bus_ctrl
  import l1_ctrl_pkg::*;
#(
  parameter int LINE_BYTES = 2048
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    req_line,
  input  logic [1:0]                    req_rd,
  input  logic [1:0]                    req_wt,
  input  logic [7:0]                    req_size,
  input  logic [127:0]                  req_pa,
  input  logic [127:0]                  req_wdata,
  output logic [63:0]                   line_data,
  output logic [$clog2(LINE_BYTES)-1:0] addr_count,
  output logic [1:0]                    line_write,
  output logic [1:0]                    entry_write,
  output logic [1:0]                    trans_rdy,
  output logic [1:0]                    bus_error,
  output logic                          bus_req,
  output logic                          bus_we,
  output logic [63:0]                   bus_addr,
  output logic [63:0]                   bus_wdata,
  output logic [3:0]                    bus_size,
  input  logic [63:0]                   bus_rdata,
  input  logic                          bus_ack,
  input  logic                          bus_err
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int CNT_W = OFF_W - 3;  // 8-byte beats
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

  state_e           state_q;
  kind_e            kind_q;
  logic             port_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      pa_q, wdata_q, hold_q;
  logic [3:0]       size_q;

  logic [1:0]  act, gnt, port_oh;
  logic        advance, sp;
  kind_e       sel_kind;
  logic [63:0] sel_pa, sel_wdata;
  logic [3:0]  sel_size;

  assign act     = req_line | req_rd | req_wt;
  assign advance = (state_q == DONE) || (state_q == ERR);

  l1_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (act),
    .advance (advance),
    .gnt     (gnt)
  );

  // Attributes of the port the arbiter is offering this cycle.
  always_comb begin
    sp        = gnt[1];
    sel_pa    = sp ? req_pa[127:64]    : req_pa[63:0];
    sel_wdata = sp ? req_wdata[127:64] : req_wdata[63:0];
    sel_size  = sp ? req_size[7:4]     : req_size[3:0];
    if (req_line[sp])    sel_kind = LINE_K;
    else if (req_rd[sp]) sel_kind = RD_K;
    else                 sel_kind = WT_K;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      kind_q  <= LINE_K;
      port_q  <= 1'b0;
      cnt_q   <= '0;
      pa_q    <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (|gnt) begin
          port_q  <= sp;
          kind_q  <= sel_kind;
          pa_q    <= sel_pa;
          wdata_q <= sel_wdata;
          size_q  <= sel_size;
          cnt_q   <= '0;
          state_q <= (sel_kind == LINE_K) ? LINE : SINGLE;
        end
        LINE: begin
          if (bus_err) state_q <= ERR;
          else if (bus_ack) begin
            // Counter parks on the last beat rather than wrapping.
            if (cnt_q == LAST_BEAT) state_q <= DONE;
            else                    cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        SINGLE: begin
          if (bus_err) state_q <= ERR;
          else if (bus_ack) begin
            hold_q  <= bus_rdata;
            state_q <= DONE;
          end
        end
        DONE, ERR: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign port_oh = port_q ? 2'b10 : 2'b01;

  always_comb begin
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_wdata   = '0;
    bus_size    = '0;
    line_write  = '0;
    addr_count  = '0;
    line_data   = hold_q;
    trans_rdy   = '0;
    entry_write = '0;
    bus_error   = '0;
    case (state_q)
      LINE: begin
        bus_req    = 1'b1;
        bus_addr   = {pa_q[63:OFF_W], cnt_q, 3'b000};
        bus_size   = SIZE_DW;
        line_data  = bus_rdata;
        addr_count = {cnt_q, 3'b000};
        // err wins over ack: a failed beat must not be written into the array
        if (bus_ack && !bus_err) line_write = port_oh;
      end
      SINGLE: begin
        bus_req   = 1'b1;
        bus_we    = (kind_q == WT_K);
        bus_addr  = pa_q;
        bus_size  = size_q;
        bus_wdata = wdata_q;
      end
      DONE: begin
        trans_rdy = port_oh;
        if (kind_q == LINE_K) entry_write = port_oh;
      end
      ERR:     bus_error = port_oh;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_l1_bus_ctrl.sv
// Self-checking bench for l1_bus_ctrl: directed plan items plus randomized
// transactions, checked against a transaction-level model of the controller.
module tb_l1_bus_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   req_line = '0, req_rd = '0, req_wt = '0;
  logic [7:0]   req_size = '0;
  logic [127:0] req_pa = '0, req_wdata = '0;
  logic [63:0]  line_data;
  logic [10:0]  addr_count;
  logic [1:0]   line_write, entry_write, trans_rdy, bus_error;
  logic         bus_req, bus_we;
  logic [63:0]  bus_addr, bus_wdata;
  logic [3:0]   bus_size;
  logic [63:0]  bus_rdata = '0;
  logic         bus_ack = 1'b0, bus_err = 1'b0;

  int errs = 0, checks = 0;
  int ptr_m = 0;  // model: port that wins when both request

  l1_bus_ctrl #(.LINE_BYTES(2048)) dut (
    .clk(clk), .rst(rst),
    .req_line(req_line), .req_rd(req_rd), .req_wt(req_wt),
    .req_size(req_size), .req_pa(req_pa), .req_wdata(req_wdata),
    .line_data(line_data), .addr_count(addr_count),
    .line_write(line_write), .entry_write(entry_write),
    .trans_rdy(trans_rdy), .bus_error(bus_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_size(bus_size),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input int k, input logic [63:0] pa,
                         input logic [3:0] sz, input logic [63:0] wd);
    req_line[p] = (k == 0);
    req_rd[p]   = (k == 1);
    req_wt[p]   = (k == 2);
    req_pa[p*64 +: 64]    = pa;
    req_size[p*4 +: 4]    = sz;
    req_wdata[p*64 +: 64] = wd;
  endtask

  task automatic clr_req(input int p);
    req_line[p] = 1'b0;
    req_rd[p]   = 1'b0;
    req_wt[p]   = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    req_line = '0; req_rd = '0; req_wt = '0;
    bus_ack = 1'b0; bus_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   bus_req, 0);
    chk("rst_we",    bus_we, 0);
    chk("rst_addr",  bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_ldata", line_data, 0);
    chk("rst_acnt",  addr_count, 0);
    chk("rst_strb",  {line_write, entry_write, trans_rdy, bus_error}, 0);
    rst = 1'b1;
    ptr_m = 0;
  endtask

  // Runs one transaction that port p is expected to win. Starts and ends just
  // after a rising edge with the DUT in IDLE. The bench plays the bus slave.
  // k: 0 line, 1 read, 2 write-through. err_beat: beat index that fails, -1 none.
  task automatic run_txn(input int p, input int k, input logic [63:0] pa,
                         input logic [3:0] sz, input logic [63:0] wd,
                         input int err_beat, input int wmin, input int wmax,
                         input logic [63:0] rd_fix, input bit use_fix, input bit chk_lat);
    int beat = 0, lw = 0, bus_cyc = 0, wl;
    bit fin = 0, got_err = 0, a, e;
    logic [63:0] rd, hold_m = '0, exp_addr;
    logic [1:0] oh;
    oh = (p == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    chk("idle_req", bus_req, 0);
    chk("idle_pulses", {entry_write, trans_rdy, bus_error}, 0);
    @(posedge clk); #1;
    wl = $urandom_range(wmax, wmin);
    while (!fin && bus_cyc < 4000) begin
      a = 0; e = 0;
      rd = {$urandom, $urandom};
      if (use_fix) rd = rd_fix;
      if (wl > 0) wl--;
      else if (beat == err_beat) e = 1;
      else a = 1;
      bus_ack = a; bus_err = e; bus_rdata = rd;
      @(negedge clk);
      exp_addr = (k == 0) ? ((pa & ~64'h7FF) + 64'(beat) * 8) : pa;
      chk("req", bus_req, 1);
      chk("addr", bus_addr, exp_addr);
      chk("we", bus_we, (k == 2));
      chk("size", bus_size, (k == 0) ? 64'd8 : 64'(sz));
      if (k == 2) chk("wdata", bus_wdata, wd);
      chk("lwr", line_write, (k == 0 && a) ? oh : 2'b00);
      if (k == 0 && a) begin
        chk("ldata", line_data, rd);
        chk("acnt", addr_count, 64'(beat) * 8);
      end
      if (line_write != 0) lw++;
      @(posedge clk); #1;
      bus_cyc++;
      if (e) begin
        fin = 1; got_err = 1;
      end else if (a) begin
        if (k == 0) begin
          beat++;
          if (beat == 256) fin = 1;
          else wl = $urandom_range(wmax, wmin);
        end else begin
          hold_m = rd; fin = 1;
        end
      end
    end
    bus_ack = 1'b0; bus_err = 1'b0;
    chk("no_timeout", fin, 1);
    @(negedge clk);
    chk("end_req", bus_req, 0);
    chk("rdy", trans_rdy, got_err ? 2'b00 : oh);
    chk("ew", entry_write, (!got_err && k == 0) ? oh : 2'b00);
    chk("berr", bus_error, got_err ? oh : 2'b00);
    if (k == 1 && !got_err) chk("rdata", line_data, hold_m);
    if (k == 0) chk("n_lwr", lw, got_err ? err_beat : 256);
    if (chk_lat) chk("latency", bus_cyc + 2, 258);
    ptr_m ^= 1;
    @(posedge clk); #1;
    clr_req(p);
  endtask

  initial begin
    int p, k, w, eb;
    logic [63:0] pa0, pa1;
    logic [3:0] sz;
    reset_dut();

    // Port1 zero-wait fill, 258 cycles request to done
    set_req(1, 0, 64'h8000_0800, 4'b1000, 0);
    run_txn(1, 0, 64'h8000_0800, 4'b1000, 0, -1, 0, 0, 0, 0, 1);
    // Port0 read with 3 wait states
    set_req(0, 1, 64'h1004, 4'b0100, 0);
    run_txn(0, 1, 64'h1004, 4'b0100, 0, -1, 3, 3, 64'hDEAD_BEEF, 1, 0);
    // Port1 write-through
    set_req(1, 2, 64'h2000, 4'b0001, 64'h55);
    run_txn(1, 2, 64'h2000, 4'b0001, 64'h55, -1, 0, 1, 0, 0, 0);

    // Both ports after reset: port0 first, then port1, twice
    reset_dut();
    repeat (2) begin
      set_req(0, 1, 64'hA000, 4'b1000, 0);
      set_req(1, 1, 64'hB000, 4'b0010, 0);
      w = ptr_m;
      chk("arb_ptr0", w, 0);
      run_txn(w, 1, (w == 0) ? 64'hA000 : 64'hB000, (w == 0) ? 4'b1000 : 4'b0010, 0, -1, 0, 2, 0, 0, 0);
      run_txn(1 - w, 1, (w == 0) ? 64'hB000 : 64'hA000, (w == 0) ? 4'b0010 : 4'b1000, 0, -1, 0, 2, 0, 0, 0);
    end

    // Bus error on fill beat 10
    set_req(1, 0, 64'h4000_0000, 4'b1000, 0);
    run_txn(1, 0, 64'h4000_0000, 4'b1000, 0, 10, 0, 1, 0, 0, 0);

    // Reset mid-fill at beat 100
    set_req(1, 0, 64'h8000_0800, 4'b1000, 0);
    @(posedge clk); #1;
    bus_ack = 1'b1;
    repeat (100) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req", bus_req, 0);
    chk("mid_rst_acnt", addr_count, 0);
    chk("mid_rst_addr", bus_addr, 0);
    chk("mid_rst_strb", {line_write, entry_write, trans_rdy, bus_error}, 0);
    bus_ack = 1'b0;
    clr_req(0); clr_req(1);
    @(posedge clk); #1;
    rst = 1'b1;
    ptr_m = 0;
    set_req(1, 0, 64'h8000_0800, 4'b1000, 0);
    run_txn(1, 0, 64'h8000_0800, 4'b1000, 0, -1, 0, 1, 0, 0, 0);

    // Randomized transactions, single and dual port
    for (int i = 0; i < 10; i++) begin
      pa0 = {$urandom, $urandom};
      pa1 = {$urandom, $urandom};
      sz = 4'b0001 << $urandom_range(3, 0);
      k = $urandom_range(2, 0);
      eb = ($urandom_range(4, 0) == 0) ? ((k == 0) ? int'($urandom_range(255, 0)) : 0) : -1;
      if ($urandom_range(1, 0) == 1) begin
        // both ports request the same kind; the model pointer picks the winner
        set_req(0, k, pa0, sz, pa1);
        set_req(1, k, pa1, sz, pa0);
        w = ptr_m;
        run_txn(w, k, (w == 0) ? pa0 : pa1, sz, (w == 0) ? pa1 : pa0, eb, 0, 2, 0, 0, 0);
        run_txn(1 - w, k, (w == 0) ? pa1 : pa0, sz, (w == 0) ? pa0 : pa1, -1, 0, 2, 0, 0, 0);
      end else begin
        p = $urandom_range(1, 0);
        set_req(p, k, pa0, sz, pa1);
        run_txn(p, k, pa0, sz, pa1, eb, 0, 2, 0, 0, 0);
      end
    end

    @(negedge clk);
    chk("final_pulses", {entry_write, trans_rdy, bus_error, line_write}, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
